// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared widths, FSM state encoding and the pending-operation record
// used by the CPU-to-tile-RAM arbiter and its posted-write buffer.
package vram_arb_pkg;

  localparam int VRAM_AW = 10;
  localparam int VRAM_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    ACCESS,
    CAPTURE,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] data;
    logic               is_wr;
  } vram_op_t;

endpackage

// File: rtl/vram_wrbuf.sv
// vram_wrbuf: one-entry posted-write buffer. A CPU write parks here so the Z80 is
// released at once; the arbiter pops the entry after the write reaches the tile RAM.
module vram_wrbuf
  import vram_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  logic     i_pop,
  input  vram_op_t i_op,
  output vram_op_t o_op,
  output logic     o_full
);

  logic     r_full;
  vram_op_t r_op;

  // Occupancy flag: set on push, cleared once the buffered write has been issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full <= 1'b1;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  // Payload capture on push.
  // NOTE: the payload is storage qualified by r_full, so it needs no reset; only
  // the valid flag is reset, which also discards any pending write.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_op <= i_op;
    end
  end

  assign o_op   = r_op;
  assign o_full = r_full;

endmodule

// File: rtl/vram_cpu_arbiter.sv
// vram_cpu_arbiter: holds the Z80 on WAIT until composite blank has been stable for
// SETTLE cycles, then issues one strobe to the tile generator RAM port. Writes can be
// posted through a one-entry buffer, which drains ahead of any new CPU access.
module vram_cpu_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned SETTLE    = 2,
  parameter bit          POSTED_WR = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmpblk,
  input  logic               cpu_sel,
  input  logic               cpu_rdn,
  input  logic               cpu_wrn,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0] cpu_din,
  output logic [VRAM_DW-1:0] cpu_dout,
  output logic               cpu_waitn,
  output logic               vram_rdn,
  output logic               vram_wrn,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_din,
  input  logic [VRAM_DW-1:0] vram_dout,
  output logic               wbuf_full
);

  localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

  arb_state_t         r_state;
  logic               r_src_buf;   // current access services the posted buffer
  vram_op_t           r_op;
  logic [2:0]         r_win_cnt;
  logic               r_vram_rdn;
  logic               r_vram_wrn;
  logic [VRAM_AW-1:0] r_vram_addr;
  logic [VRAM_DW-1:0] r_vram_din;
  logic [VRAM_DW-1:0] r_cpu_dout;

  logic     w_req;
  logic     w_req_wr;
  logic     w_win_ok;
  logic     w_post_accept;
  logic     w_pop;
  logic     w_buf_full;
  vram_op_t w_req_op;
  vram_op_t w_buf_op;
  vram_op_t w_cur_op;

  // Both strobes low is treated as a write.
  assign w_req         = cpu_sel & (~cpu_rdn | ~cpu_wrn);
  assign w_req_wr      = ~cpu_wrn;
  assign w_req_op      = '{addr: cpu_addr, data: cpu_din, is_wr: w_req_wr};
  assign w_win_ok      = cmpblk && (r_win_cnt == SETTLE_CNT);
  assign w_post_accept = POSTED_WR && (r_state == IDLE) && w_req && w_req_wr && !w_buf_full;
  assign w_pop         = (r_state == ACCESS) && r_src_buf && cmpblk;
  assign w_cur_op      = r_src_buf ? w_buf_op : r_op;

  vram_wrbuf u_wrbuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_post_accept),
    .i_pop  (w_pop),
    .i_op   (w_req_op),
    .o_op   (w_buf_op),
    .o_full (w_buf_full)
  );

  // Blank-window counter: restarts on every rising cmpblk, saturates at SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
    end else if (!cmpblk) begin
      r_win_cnt <= '0;
    end else if (r_win_cnt != SETTLE_CNT) begin
      r_win_cnt <= r_win_cnt + 3'd1;
    end
  end

  // Access sequencer with registered strobe, address, data and read-capture outputs.
  // NOTE: every state element here uses non-blocking assignment so all registers
  // update from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_src_buf   <= 1'b0;
      r_op        <= '0;
      r_vram_rdn  <= 1'b1;
      r_vram_wrn  <= 1'b1;
      r_vram_addr <= '0;
      r_vram_din  <= '0;
      r_cpu_dout  <= '0;
    end else begin
      r_vram_rdn <= 1'b1;
      r_vram_wrn <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_buf_full) begin
            r_src_buf <= 1'b1;
            r_state   <= WAIT_WIN;
          end else if (w_req) begin
            r_src_buf <= 1'b0;
            r_op      <= w_req_op;
            r_state   <= w_post_accept ? DONE : WAIT_WIN;
          end
        end
        WAIT_WIN: begin
          if (!r_src_buf && !r_op.is_wr && !w_req) begin
            r_state <= IDLE;                 // abandoned read; writes always finish
          end else if (w_win_ok) begin
            r_state     <= ACCESS;
            r_vram_rdn  <= w_cur_op.is_wr;
            r_vram_wrn  <= ~w_cur_op.is_wr;
            r_vram_addr <= w_cur_op.addr;
            if (w_cur_op.is_wr) begin
              r_vram_din <= w_cur_op.data;
            end
          end
        end
        ACCESS: begin
          if (!cmpblk) begin
            r_state <= WAIT_WIN;             // window closed under the strobe: retry
          end else if (r_src_buf) begin
            r_src_buf <= 1'b0;
            r_state   <= IDLE;
          end else if (r_op.is_wr) begin
            r_state <= DONE;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_cpu_dout <= vram_dout;
          r_state    <= DONE;
        end
        DONE: begin
          if (!cpu_sel || (cpu_rdn && cpu_wrn)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // WAIT is combinational so the Z80 is stalled in the very cycle it asks.
  // NOTE: cpu_waitn gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cpu_waitn = 1'b1;
    case (r_state)
      IDLE:                      if (w_req && !w_post_accept) cpu_waitn = 1'b0;
      WAIT_WIN, ACCESS, CAPTURE: if (!r_src_buf || w_req)     cpu_waitn = 1'b0;
      default:                   cpu_waitn = 1'b1;
    endcase
  end

  // The registered strobe is masked by cmpblk so a window that closes during
  // ACCESS never presents a strobe; the sequencer then retries.
  assign vram_rdn  = r_vram_rdn | ~cmpblk;
  assign vram_wrn  = r_vram_wrn | ~cmpblk;
  assign vram_addr = r_vram_addr;
  assign vram_din  = r_vram_din;
  assign cpu_dout  = r_cpu_dout;
  assign wbuf_full = w_buf_full;

endmodule

// File: tb/tb_vram_cpu_arbiter.sv
// tb_vram_cpu_arbiter: directed scenarios for the blank-window timing plus a random
// Z80 traffic phase scored against a shadow memory kept in program order.
module tb_vram_cpu_arbiter;

  localparam int SETTLE = 2;
  localparam int BOUND  = 200;
  localparam int N_RND  = 150;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmpblk = 1'b0;
  logic       cpu_sel = 1'b0;
  logic       cpu_rdn = 1'b1;
  logic       cpu_wrn = 1'b1;
  logic [9:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic [7:0] cpu_dout;
  logic       cpu_waitn;
  logic       vram_rdn;
  logic       vram_wrn;
  logic [9:0] vram_addr;
  logic [7:0] vram_din;
  logic [7:0] vram_dout = '0;
  logic       wbuf_full;

  int total = 0;
  int bad   = 0;

  // Tile RAM stand-in and strobe monitor state.
  logic [7:0] mem    [1024];
  logic [7:0] shadow [1024];
  bit         filled = 1'b0;
  bit         poke_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [7:0] poke_val = '0;
  int         cyc = 0;
  int         hi_run = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         viol = 0;
  int         last_strobe_cyc = -1;
  logic [9:0] last_addr = '0;

  bit cmp_auto = 1'b0;
  int cmp_rem  = 0;

  vram_cpu_arbiter #(.SETTLE(SETTLE), .POSTED_WR(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmpblk    (cmpblk),
    .cpu_sel   (cpu_sel),
    .cpu_rdn   (cpu_rdn),
    .cpu_wrn   (cpu_wrn),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_waitn (cpu_waitn),
    .vram_rdn  (vram_rdn),
    .vram_wrn  (vram_wrn),
    .vram_addr (vram_addr),
    .vram_din  (vram_din),
    .vram_dout (vram_dout),
    .wbuf_full (wbuf_full)
  );

  always #5 clk = ~clk;

  // RAM honours strobes at the clock edge; read data appears one cycle later.
  // A strobe is legal only after cmpblk has been high SETTLE+1 prior cycles and now.
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5);
      filled <= 1'b1;
    end
    if (poke_en) mem[poke_addr] <= poke_val;
    if (!vram_rdn || !vram_wrn) begin
      if (!(cmpblk && hi_run >= SETTLE + 1)) viol <= viol + 1;
      last_strobe_cyc <= cyc;
      last_addr       <= vram_addr;
      if (!vram_rdn) begin
        rd_cnt    <= rd_cnt + 1;
        vram_dout <= mem[vram_addr];
      end
      if (!vram_wrn) begin
        wr_cnt         <= wr_cnt + 1;
        mem[vram_addr] <= vram_din;
      end
    end
    hi_run <= cmpblk ? hi_run + 1 : 0;
    cyc    <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // One cycle; in random mode cmpblk alternates in runs of random length.
  task automatic step();
    @(negedge clk);
    if (cmp_auto) begin
      if (cmp_rem == 0) begin
        cmpblk  = ~cmpblk;
        cmp_rem = cmpblk ? $urandom_range(1, 12) : $urandom_range(1, 15);
      end else begin
        cmp_rem--;
      end
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] v);
    poke_addr = a;
    poke_val  = v;
    poke_en   = 1'b1;
    step();
    poke_en   = 1'b0;
  endtask

  // Z80 bus cycle: hold the strobe until WAIT releases, then end the cycle.
  // rise_at/fall_at move cmpblk at the given cycle offset from the request.
  task automatic z80_access(input bit wr, input logic [9:0] a, input logic [7:0] d,
                            input int rise_at, input int fall_at,
                            output int lows, output int rise_cyc, output int req_cyc);
    cpu_sel  = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    cpu_rdn  = wr;
    cpu_wrn  = !wr;
    req_cyc  = cyc;
    rise_cyc = -1;
    lows     = 0;
    for (int k = 0; k < BOUND; k++) begin
      if (k == rise_at) begin
        cmpblk   = 1'b1;
        rise_cyc = cyc;
      end
      if (k == fall_at) cmpblk = 1'b0;
      #1;
      if (cpu_waitn === 1'b1) break;
      lows++;
      step();
    end
    check("waitn_release", cpu_waitn, 1);
    step();
    cpu_sel = 1'b0;
    cpu_rdn = 1'b1;
    cpu_wrn = 1'b1;
    step();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {cpu_waitn, vram_rdn, vram_wrn, wbuf_full}, 4'b1110);
    check({tag, "_addr"}, vram_addr, 0);
    check({tag, "_data"}, {vram_din, cpu_dout}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lows, rc, qc, lows2, rd0, wr0, nbad;
    bit         wr;
    logic [9:0] a;
    logic [7:0] d;

    // Reset state.
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst0");
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Read with the window already open.
    cmpblk = 1'b1;
    poke(10'h155, 8'hA5);
    repeat (4) step();
    rd0 = rd_cnt;
    z80_access(1'b0, 10'h155, 8'h00, -1, -1, lows, rc, qc);
    check("rd_open_lows", lows, 4);
    check("rd_open_dout", cpu_dout, 8'hA5);
    check("rd_open_pulses", rd_cnt - rd0, 1);
    check("rd_open_addr", last_addr, 10'h155);
    check("rd_open_when", last_strobe_cyc, qc + 2);

    // Read in active video, blank rising 20 cycles later.
    poke(10'h2AA, 8'h5A);
    cmpblk = 1'b0;
    repeat (2) step();
    rd0 = rd_cnt;
    z80_access(1'b0, 10'h2AA, 8'h00, 20, -1, lows, rc, qc);
    check("rd_video_when", last_strobe_cyc, rc + SETTLE + 1);
    check("rd_video_lows", lows, 20 + SETTLE + 3);
    check("rd_video_dout", cpu_dout, 8'h5A);
    check("rd_video_pulses", rd_cnt - rd0, 1);

    // Window closes during ACCESS: suppressed strobe, retry in the next window.
    poke(10'h0F0, 8'h3E);
    repeat (4) step();
    rd0 = rd_cnt;
    z80_access(1'b0, 10'h0F0, 8'h00, 6, 2, lows, rc, qc);
    check("rd_close_pulses", rd_cnt - rd0, 1);
    check("rd_close_when", last_strobe_cyc, qc + 6 + SETTLE + 1);
    check("rd_close_lows", lows, 6 + SETTLE + 3);
    check("rd_close_dout", cpu_dout, 8'h3E);

    // Back-to-back posted writes during active video.
    cmpblk = 1'b0;
    repeat (2) step();
    wr0 = wr_cnt;
    z80_access(1'b1, 10'h000, 8'h3C, -1, -1, lows, rc, qc);
    check("pw1_lows", lows, 0);
    z80_access(1'b1, 10'h3FF, 8'hC3, 10, -1, lows2, rc, qc);
    check("pw2_lows", lows2, 10 + SETTLE + 2);
    repeat (8) step();
    check("pw_ram0", mem[0], 8'h3C);
    check("pw_ram3ff", mem[1023], 8'hC3);
    check("pw_pulses", wr_cnt - wr0, 2);
    check("pw_empty", wbuf_full, 1'b0);

    // Read-after-write through the posted buffer.
    poke(10'h010, 8'h00);
    z80_access(1'b1, 10'h010, 8'h77, -1, -1, lows, rc, qc);
    check("raw_wr_lows", lows, 0);
    z80_access(1'b0, 10'h010, 8'h00, -1, -1, lows, rc, qc);
    check("raw_dout", cpu_dout, 8'h77);
    check("raw_rd_lows", lows, 7);

    // Reset while a buffered write waits for the window.
    poke(10'h123, 8'h11);
    cmpblk = 1'b0;
    repeat (2) step();
    wr0 = wr_cnt;
    z80_access(1'b1, 10'h123, 8'hEE, -1, -1, lows, rc, qc);
    repeat (2) step();
    check("rst_pre_full", wbuf_full, 1'b1);
    rst_n = 1'b0;
    #1 check_reset_outs("rst1");
    repeat (2) step();
    rst_n  = 1'b1;
    cmpblk = 1'b1;
    repeat (10) step();
    check("rst_no_strobe", wr_cnt - wr0, 0);
    check("rst_ram_kept", mem[10'h123], 8'h11);
    check("rst_buf_empty", wbuf_full, 1'b0);

    // Random traffic against the shadow memory.
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    cmp_auto = 1'b1;
    for (int n = 0; n < N_RND; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
      d  = 8'($urandom);
      z80_access(wr, a, d, -1, -1, lows, rc, qc);
      if (wr) shadow[a] = d;
      else    check("rnd_rd", cpu_dout, shadow[a]);
      repeat ($urandom_range(0, 2)) step();
    end
    cmp_auto = 1'b0;
    cmpblk   = 1'b1;
    repeat (12) step();
    nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== shadow[i]) nbad++;
    check("ram_final", nbad, 0);
    check("strobe_window", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
